// File: rtl/alu_seq_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential
// two-requester ALU controller.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_LO   = 2'd1;
  localparam state_t S_HI   = 2'd2;
  localparam state_t S_RSP  = 2'd3;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_slice16.sv
// One ALU slice (AND/OR/add with b-invert); op[2] selects b-invert,
// carry-in comes from the caller so slices can be chained in time.
module alu_slice16
  import alu_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic [2:0]   op,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         msb,
  output logic         overflow
);

  logic [W-1:0] bx;
  logic [W:0]   sum;

  always_comb begin
    bx  = op[2] ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
  end

  always_comb begin
    result = '0;
    unique case (1'b1)
      op[1]:            result = sum[W-1:0];
      !op[1] && op[0]:  result = a | b;
      !op[1] && !op[0]: result = a & b;
      default:          result = '0;
    endcase
  end

  assign cout     = sum[W];
  assign msb      = sum[W-1];
  assign overflow = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Two-requester ALU sequencer: one 16-bit slice computes low then high half.
// Define ALU_SEQ_RR_EN for round-robin arbitration (default: requester 0 wins).
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_set,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             busy
);

  state_t               state;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2:0]           op_q;
  logic [SLICE_W-1:0]   lo_r;
  logic                 lo_c;
  logic                 lo_z;

  logic                 gnt;
  logic                 gid;
  logic                 s_hi;
  logic [SLICE_W-1:0]   s_a;
  logic [SLICE_W-1:0]   s_b;
  logic                 s_cin;
  logic [SLICE_W-1:0]   s_res;
  logic                 s_cout;
  logic                 s_msb;
  logic                 s_ovf;

  logic                 slt;
  logic                 arith;
  logic                 legal;
  logic                 set_d;
  logic [WIDTH-1:0]     fin;
  logic                 zero_d;

  assign gnt = rst_n && (state == S_IDLE) && (|req_valid);

`ifdef ALU_SEQ_RR_EN
  // prio names the requester favoured on a tie
  logic prio;

  assign gid = req_valid[0] ? (req_valid[1] & prio) : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (gnt) begin
      prio <= ~gid;
    end
  end
`else
  assign gid = ~req_valid[0];
`endif

  assign req_ready = gnt ? (gid ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state == S_RSP);
  assign busy      = (state != S_IDLE);

  assign s_hi  = (state == S_HI);
  assign s_a   = s_hi ? a_q[WIDTH-1:SLICE_W] : a_q[SLICE_W-1:0];
  assign s_b   = s_hi ? b_q[WIDTH-1:SLICE_W] : b_q[SLICE_W-1:0];
  assign s_cin = s_hi ? lo_c : op_q[2];

  alu_slice16 #(
    .W (SLICE_W)
  ) u_slice (
    .a        (s_a),
    .b        (s_b),
    .cin      (s_cin),
    .op       (op_q),
    .result   (s_res),
    .cout     (s_cout),
    .msb      (s_msb),
    .overflow (s_ovf)
  );

  // Final result is assembled while the slice works on the high half
  always_comb begin
    slt    = (op_q == OP_SLT);
    arith  = (op_q == OP_ADD) || (op_q == OP_SUB);
    legal  = op_legal(op_q);
    set_d  = slt & (s_msb ^ s_ovf);
    fin    = '0;
    zero_d = 1'b1;
    if (slt) begin
      fin    = {{(WIDTH-1){1'b0}}, set_d};
      zero_d = ~set_d;
    end else if (legal) begin
      fin    = {s_res, lo_r};
      zero_d = lo_z & (s_res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      lo_r         <= '0;
      lo_c         <= 1'b0;
      lo_z         <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_set      <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt) begin
            a_q    <= gid ? req1_a : req0_a;
            b_q    <= gid ? req1_b : req0_b;
            op_q   <= gid ? req1_op : req0_op;
            rsp_id <= gid;
            state  <= S_LO;
          end
        end
        S_LO: begin
          lo_r  <= s_res;
          lo_c  <= s_cout;
          lo_z  <= (s_res == '0);
          state <= S_HI;
        end
        S_HI: begin
          rsp_result   <= fin;
          rsp_set      <= set_d;
          rsp_zero     <= zero_d;
          rsp_overflow <= arith & s_ovf;
          state        <= S_RSP;
        end
        default: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed cases plus random ops
// compared against a whole-word arithmetic model.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_set, rsp_zero, rsp_overflow, busy;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  logic fav = 1'b0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_op      (req0_op),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_op      (req1_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_set      (rsp_set),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {overflow, set, zero, result}
  function automatic logic [34:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [2:0] op);
    logic [31:0] r;
    logic s, v;
    r = '0; s = 1'b0; v = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        r = a + b;
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b110: begin
        r = a - b;
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b111: begin
        s = $signed(a) < $signed(b);
        r = {31'b0, s};
      end
      default: r = '0;
    endcase
    return {v, s, (r == 32'd0), r};
  endfunction

  task automatic run_op(input logic [1:0] v,
                        input logic [31:0] a0, input logic [31:0] b0,
                        input logic [2:0] o0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic [2:0] o1,
                        input int stall, input string tag,
                        output logic gid);
    logic [34:0] e;
    logic eid;
    int n;
    @(negedge clk);
    req_valid = v;
    req0_a = a0; req0_b = b0; req0_op = o0;
    req1_a = a1; req1_b = b1; req1_op = o1;
    if (v == 2'b01) eid = 1'b0;
    else if (v == 2'b10) eid = 1'b1;
    else begin
`ifdef ALU_SEQ_RR_EN
      eid = fav;
`else
      eid = 1'b0;
`endif
    end
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, ":grant"}, {30'b0, req_ready}, eid ? 32'd2 : 32'd1);
    gid = req_ready[1];
    fav = ~eid;
    e = eid ? model(a1, b1, o1) : model(a0, b0, o0);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
      if (n == 1) begin
        chk({tag, ":ready_lo"}, {30'b0, req_ready}, 32'd0);
        req_valid = 2'b00;
      end
    end while (!rsp_valid && n < 10);
    chk({tag, ":latency"}, n, 32'd3);
    chk({tag, ":result"}, rsp_result, e[31:0]);
    chk({tag, ":flags"}, {29'b0, rsp_overflow, rsp_set, rsp_zero},
        {29'b0, e[34:32]});
    chk({tag, ":id"}, {31'b0, rsp_id}, {31'b0, eid});
    for (int i = 0; i < stall; i++) begin
      req_valid = 2'b11;
      @(negedge clk); #1;
      chk({tag, ":hold_res"}, rsp_result, e[31:0]);
      chk({tag, ":hold_ctl"},
          {27'b0, rsp_valid, req_ready, busy, rsp_id},
          {27'b0, 1'b1, 2'b00, 1'b1, eid});
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk({tag, ":done"}, {30'b0, rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    logic g;
    logic [1:0] v;
    logic [2:0] o0, o1;
    logic [31:0] ra [4];
    int seen;
    logic [2:0] ops [8];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110;
    ops[4] = 3'b111; ops[5] = 3'b011; ops[6] = 3'b100; ops[7] = 3'b101;

    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    #1;
    chk("reset_out", {rsp_result[27:0], req_ready, rsp_valid, busy}, 32'd0);
    chk("reset_flags", {28'b0, rsp_id, rsp_set, rsp_zero, rsp_overflow},
        32'd0);
    repeat (2) @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;

    // simultaneous requests right after reset
    for (int k = 0; k < 4; k++) begin
      run_op(2'b11, 32'd10, 32'd3, 3'b010, 32'd10, 32'd3, 3'b110, 0,
             $sformatf("tie%0d", k), g);
    end

    run_op(2'b01, 32'h7FFFFFFF, 32'h1, 3'b010, 32'h0, 32'h0, 3'b000, 0,
           "add_ovf", g);
    run_op(2'b10, 32'h0, 32'h0, 3'b000, 32'h0000FFFF, 32'h1, 3'b010, 0,
           "add_carry", g);
    run_op(2'b01, 32'd5, 32'd5, 3'b110, 32'h0, 32'h0, 3'b000, 0,
           "sub_zero", g);
    run_op(2'b01, 32'hFFFFFFFF, 32'h1, 3'b111, 32'h0, 32'h0, 3'b000, 0,
           "slt_a", g);
    run_op(2'b10, 32'h0, 32'h0, 3'b000, 32'h80000000, 32'h7FFFFFFF, 3'b111,
           0, "slt_b", g);
    run_op(2'b01, 32'h1, 32'hFFFFFFFF, 3'b111, 32'h0, 32'h0, 3'b000, 0,
           "slt_c", g);
    run_op(2'b01, 32'h1234, 32'h5678, 3'b101, 32'h0, 32'h0, 3'b000, 0,
           "illegal", g);
    run_op(2'b10, 32'h0, 32'h0, 3'b000, 32'hF0F0A5A5, 32'h0FF0FFFF, 3'b000,
           5, "stall", g);

    // reset while the high half is in flight
    @(negedge clk);
    req_valid = 2'b01;
    req0_a = 32'd100; req0_b = 32'd200; req0_op = 3'b010;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {29'b0, rsp_valid, busy, rsp_result[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fav = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("rst_no_rsp", seen, 32'd0);
    run_op(2'b01, 32'd2, 32'd3, 3'b010, 32'h0, 32'h0, 3'b000, 0,
           "post_rst", g);

    for (int k = 0; k < 40; k++) begin
      v = 2'($urandom_range(1, 3));
      o0 = ops[$urandom_range(0, 7)];
      o1 = ops[$urandom_range(0, 7)];
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 5))
          0: ra[j] = 32'h7FFFFFFF;
          1: ra[j] = 32'h80000000;
          2: ra[j] = 32'h0000FFFF;
          default: ra[j] = $urandom;
        endcase
      end
      run_op(v, ra[0], ra[1], o0, ra[2], ra[3], o1,
             int'($urandom_range(0, 2)), $sformatf("rnd%0d", k), g);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; SHALL equal 2*SLICE_W.
REQ-002 Parameter: SLICE_W, 16, width of the single shared ALU slice.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: req_valid  in  2  per-requester request valid (bit 0 = requester 0).
REQ-007 Port: req_ready  out  2  per-requester accept strobe.
REQ-008 Port: req0_a, req0_b  in  32 each  requester-0 operands; req0_op  in  3  requester-0 opcode.
REQ-009 Port: req1_a, req1_b  in  32 each  requester-1 operands; req1_op  in  3  requester-1 opcode.
REQ-010 Port: rsp_valid  out  1  response valid; rsp_ready  in  1  response accept.
REQ-011 Port: rsp_id  out  1  requester index of the response.
REQ-012 Port: rsp_result  out  32; rsp_set, rsp_zero, rsp_overflow  out  1 each  result flags.
REQ-013 Port: busy  out  1  high in every state except IDLE.

Function
REQ-014 Opcodes SHALL be: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; op[2] SHALL drive slice carry-in and b-invert.
REQ-015 The FSM SHALL have states IDLE, LO, HI, RSP; transitions: IDLE->LO on grant, LO->HI, HI->RSP, RSP->IDLE on rsp_ready.
REQ-016 In IDLE with any req_valid set, the block SHALL grant exactly one requester, pulse its req_ready for that cycle, and capture a, b, op and id.
REQ-017 req_ready SHALL be 0 in LO, HI and RSP regardless of req_valid.
REQ-018 LO SHALL compute bits [15:0] with carry-in op[2] and register result, carry-out and low-half zero.
REQ-019 HI SHALL compute bits [31:16] with carry-in equal to the registered LO carry-out.
REQ-020 rsp_overflow SHALL equal signed overflow for ADD and SUB, and 0 for all other opcodes.
REQ-021 For SLT, rsp_result SHALL be {31'b0, set}, with set = MSB(a-b) XOR overflow(a-b); rsp_set SHALL be 0 for all other opcodes.
REQ-022 rsp_zero SHALL be 1 exactly when the final 32-bit rsp_result is 0.
REQ-023 Opcodes 011, 100 and 101 SHALL produce rsp_result 0, rsp_zero 1, rsp_set 0, rsp_overflow 0.
REQ-024 rsp_valid SHALL rise exactly 3 cycles after the req_ready cycle.
REQ-025 rsp_* outputs SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-026 The earliest next grant SHALL be the cycle after the rsp_valid&rsp_ready handshake; the minimum period is 4 cycles per operation.
REQ-027 When only one req_valid bit is set, that requester SHALL be granted irrespective of arbitration state.

Reset
REQ-028 On rst_n low, the block SHALL immediately enter IDLE and drive all outputs to 0; the arbitration pointer SHALL favour requester 0.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight operation with no response produced.

Configuration
REQ-030 Macro ALU_SEQ_RR_EN: when defined, simultaneous requests SHALL be granted round-robin, favouring the requester not granted last.
REQ-031 When ALU_SEQ_RR_EN is undefined, simultaneous requests SHALL always grant requester 0, and no pointer register SHALL exist.

Structure
REQ-032 Package alu_seq_pkg SHALL hold the opcode constants and the FSM state typedef.
REQ-033 The block SHALL instantiate exactly one sub-module, alu_slice16 (a, b, cin, op -> result, cout, msb overflow), time-shared across LO and HI.

Verification
REQ-034 Req0 ADD 0x7FFFFFFF+0x00000001 -> rsp_result 0x80000000, overflow 1, zero 0, id 0, rsp_valid 3 cycles after accept.
REQ-035 ADD 0x0000FFFF+0x00000001 -> 0x00010000 (cross-half carry); SUB 5-5 -> 0, zero 1.
REQ-036 SLT 0xFFFFFFFF,0x00000001 -> 1, set 1; SLT 0x80000000,0x7FFFFFFF -> 1; SLT 1,0xFFFFFFFF -> 0, zero 1.
REQ-037 Both req_valid held high for 4 ops -> grant order 0,1,0,1 with ALU_SEQ_RR_EN, and 0,0,0,0 without.
REQ-038 rsp_ready held low 5 cycles in RSP -> outputs stable, req_ready 00, busy 1; then one response on release.
REQ-039 rst_n pulsed low during HI -> rsp_valid 0 at once, no response; the next ADD 2+3 returns 5.
